// File: rtl/game_geometry_pkg.sv
// Shared geometry, palette and colour constants for the frame renderer.
// Block sizes must be powers of two; the row palette has one entry per block row.
package game_geometry_pkg;

  localparam int BLOCK_COLS  = 9;
  localparam int BLOCK_ROWS  = 8;
  localparam int BLOCK_X0    = 32;
  localparam int BLOCK_Y0    = 48;
  localparam int BLOCK_W     = 64;
  localparam int BLOCK_H     = 16;
  localparam int BALL_SIZE   = 8;
  localparam int PADDLE_LEN  = 64;
  localparam int PADDLE_Y    = 448;
  localparam int PADDLE_H    = 8;
  localparam int CEIL_H      = 16;

  localparam int NUM_BLOCKS  = BLOCK_COLS * BLOCK_ROWS;
  localparam int BLOCK_IDX_W = $clog2(NUM_BLOCKS);

  localparam logic [7:0] COLOUR_BALL   = 8'hFF;
  localparam logic [7:0] COLOUR_PADDLE = 8'h1F;
  localparam logic [7:0] COLOUR_WALL   = 8'h92;
  localparam logic [7:0] COLOUR_BG     = 8'h00;
  localparam logic [7:0] COLOUR_LOST   = 8'h20;

  // RGB332 per block row, top row first.
  localparam logic [7:0] ROW_COLOUR [8] = '{
    8'hE0, 8'hEC, 8'hFC, 8'h1C, 8'h13, 8'h03, 8'h63, 8'hE3
  };

endpackage

// File: rtl/block_index_lookup.sv
// Pipeline stage 2 of the renderer: turns (row, col) into a block index with
// shift-add arithmetic and registers the presence bit plus the row for palette lookup.
module block_index_lookup #(
  parameter int BLOCK_COLS = game_geometry_pkg::BLOCK_COLS,
  parameter int BLOCK_ROWS = game_geometry_pkg::BLOCK_ROWS,
  parameter int ROW_W      = $clog2(game_geometry_pkg::BLOCK_ROWS),
  parameter int COL_W      = $clog2(game_geometry_pkg::BLOCK_COLS),
  parameter int IDX_W      = game_geometry_pkg::BLOCK_IDX_W
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [ROW_W-1:0]                 row_i,
  input  logic [COL_W-1:0]                 col_i,
  input  logic                             area_i,
  input  logic [BLOCK_COLS*BLOCK_ROWS-1:0] blocks_i,
  output logic                             hit_o,
  output logic [ROW_W-1:0]                 row_o
);

  localparam int PAD_W = 1 << IDX_W;

  logic [IDX_W-1:0] idx;
  logic [PAD_W-1:0] blocks_pad;
  logic             hit_d;
  logic             hit_q;
  logic [ROW_W-1:0] row_q;

  // row*BLOCK_COLS as a sum of row shifted by each set bit of the constant.
  always_comb begin
    idx = IDX_W'(col_i);
    for (int b = 0; b < 32; b++) begin
      if (BLOCK_COLS[b]) idx = idx + (IDX_W'(row_i) << b);
    end
  end

  assign blocks_pad = PAD_W'(blocks_i);
  assign hit_d      = area_i && blocks_pad[idx];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_q <= 1'b0;
      row_q <= '0;
    end else begin
      hit_q <= hit_d;
      row_q <= row_i;
    end
  end

  assign hit_o = hit_q;
  assign row_o = row_q;

endmodule

// File: rtl/frame_renderer.sv
// Snapshots physics state at vblank and renders RGB332 pixels through a 2-stage pipeline.
// Optional FRAME_RENDERER_OUTLINE_EN draws a 1-px dark grid on block edges.
module frame_renderer #(
  parameter int BLOCK_COLS = game_geometry_pkg::BLOCK_COLS,
  parameter int BLOCK_ROWS = game_geometry_pkg::BLOCK_ROWS,
  parameter int BLOCK_X0   = game_geometry_pkg::BLOCK_X0,
  parameter int BLOCK_Y0   = game_geometry_pkg::BLOCK_Y0,
  parameter int BLOCK_W    = game_geometry_pkg::BLOCK_W,
  parameter int BLOCK_H    = game_geometry_pkg::BLOCK_H,
  parameter int BALL_SIZE  = game_geometry_pkg::BALL_SIZE,
  parameter int PADDLE_LEN = game_geometry_pkg::PADDLE_LEN,
  parameter int PADDLE_Y   = game_geometry_pkg::PADDLE_Y,
  parameter int PADDLE_H   = game_geometry_pkg::PADDLE_H,
  parameter int CEIL_H     = game_geometry_pkg::CEIL_H
) (
  input  logic                             CLK,
  input  logic                             RESET_N,
  input  logic [9:0]                       PIX_X,
  input  logic [9:0]                       PIX_Y,
  input  logic                             PIX_VALID,
  input  logic                             FRAME_END,
  input  logic [9:0]                       PADDLE_X_PIXEL,
  input  logic [9:0]                       BALL_X_PIXEL,
  input  logic [9:0]                       BALL_Y_PIXEL,
  input  logic [BLOCK_COLS*BLOCK_ROWS-1:0] BLOCK_STATE,
  input  logic                             BALL_LOST,
  output logic                             START_UPDATE,
  output logic [7:0]                       RGB,
  output logic                             RGB_VALID
);

  import game_geometry_pkg::*;

  localparam int NB    = BLOCK_COLS * BLOCK_ROWS;
  localparam int COL_W = $clog2(BLOCK_COLS);
  localparam int ROW_W = $clog2(BLOCK_ROWS);
  localparam int IDX_W = $clog2(NB);
  localparam int BW_SH = $clog2(BLOCK_W);
  localparam int BH_SH = $clog2(BLOCK_H);

  localparam logic [9:0] X0     = 10'(BLOCK_X0);
  localparam logic [9:0] Y0     = 10'(BLOCK_Y0);
  localparam logic [9:0] X_END  = 10'(BLOCK_X0 + BLOCK_COLS * BLOCK_W);
  localparam logic [9:0] PAD_Y0 = 10'(PADDLE_Y);
  localparam logic [9:0] PAD_Y1 = 10'(PADDLE_Y + PADDLE_H);
  localparam logic [9:0] CEIL   = 10'(CEIL_H);
  localparam logic [9:0] BALL_E = 10'(BALL_SIZE);
  localparam logic [9:0] PAD_L  = 10'(PADDLE_LEN);
  localparam logic [9:0] N_COLS = 10'(BLOCK_COLS);
  localparam logic [9:0] N_ROWS = 10'(BLOCK_ROWS);

  logic [9:0]    paddle_x_q, ball_x_q, ball_y_q;
  logic [NB-1:0] blocks_q, blocks_s2_q;
  logic          lost_q, snap_q, start_q;

  // blocks_s2_q trails the shadow by one cycle so stage 2 sees the same snapshot
  // stage 1 used for that pixel, even across a capture edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      paddle_x_q  <= '0;
      ball_x_q    <= '0;
      ball_y_q    <= '0;
      blocks_q    <= '0;
      blocks_s2_q <= '0;
      lost_q      <= 1'b0;
      snap_q      <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      start_q     <= FRAME_END;
      blocks_s2_q <= blocks_q;
      if (FRAME_END) begin
        paddle_x_q <= PADDLE_X_PIXEL;
        ball_x_q   <= BALL_X_PIXEL;
        ball_y_q   <= BALL_Y_PIXEL;
        blocks_q   <= BLOCK_STATE;
        lost_q     <= BALL_LOST;
        snap_q     <= 1'b1;
      end
    end
  end

  logic [9:0] dx_ball, dy_ball, dx_pad, bx, by, col_full, row_full;
  logic       in_ball_d, in_pad_d, in_area_d, in_wall_d;

  // Unsigned wrap-around makes left/above misses fail the "< size" tests.
  always_comb begin
    dx_ball   = PIX_X - ball_x_q;
    dy_ball   = PIX_Y - ball_y_q;
    dx_pad    = PIX_X - paddle_x_q;
    bx        = PIX_X - X0;
    by        = PIX_Y - Y0;
    col_full  = bx >> BW_SH;
    row_full  = by >> BH_SH;
    in_ball_d = snap_q && (dx_ball < BALL_E) && (dy_ball < BALL_E);
    in_pad_d  = snap_q && (dx_pad < PAD_L) && (PIX_Y >= PAD_Y0) && (PIX_Y < PAD_Y1);
    in_area_d = snap_q && (PIX_X >= X0) && (PIX_Y >= Y0) &&
                (col_full < N_COLS) && (row_full < N_ROWS);
    in_wall_d = snap_q && ((PIX_X < X0) || (PIX_X >= X_END) || (PIX_Y < CEIL));
  end

  logic             s1_valid_q, s1_ball_q, s1_pad_q, s1_area_q, s1_wall_q, s1_lost_q;
  logic [ROW_W-1:0] s1_row_q;
  logic [COL_W-1:0] s1_col_q;
  logic             s2_valid_q, s2_ball_q, s2_pad_q, s2_wall_q, s2_lost_q;
  logic             s2_hit;
  logic [ROW_W-1:0] s2_row;
`ifdef FRAME_RENDERER_OUTLINE_EN
  logic             edge_d, s1_edge_q, s2_edge_q;
  assign edge_d = (bx[BW_SH-1:0] == '0) || (by[BH_SH-1:0] == '0);
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_valid_q <= 1'b0;
      s1_ball_q  <= 1'b0;
      s1_pad_q   <= 1'b0;
      s1_area_q  <= 1'b0;
      s1_wall_q  <= 1'b0;
      s1_lost_q  <= 1'b0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_ball_q  <= 1'b0;
      s2_pad_q   <= 1'b0;
      s2_wall_q  <= 1'b0;
      s2_lost_q  <= 1'b0;
`ifdef FRAME_RENDERER_OUTLINE_EN
      s1_edge_q  <= 1'b0;
      s2_edge_q  <= 1'b0;
`endif
    end else begin
      s1_valid_q <= PIX_VALID;
      s1_ball_q  <= in_ball_d;
      s1_pad_q   <= in_pad_d;
      s1_area_q  <= in_area_d;
      s1_wall_q  <= in_wall_d;
      s1_lost_q  <= snap_q && lost_q;
      s1_row_q   <= row_full[ROW_W-1:0];
      s1_col_q   <= col_full[COL_W-1:0];
      s2_valid_q <= s1_valid_q;
      s2_ball_q  <= s1_ball_q;
      s2_pad_q   <= s1_pad_q;
      s2_wall_q  <= s1_wall_q;
      s2_lost_q  <= s1_lost_q;
`ifdef FRAME_RENDERER_OUTLINE_EN
      s1_edge_q  <= edge_d;
      s2_edge_q  <= s1_edge_q;
`endif
    end
  end

  block_index_lookup #(
    .BLOCK_COLS (BLOCK_COLS),
    .BLOCK_ROWS (BLOCK_ROWS),
    .ROW_W      (ROW_W),
    .COL_W      (COL_W),
    .IDX_W      (IDX_W)
  ) u_block_index_lookup (
    .clk_i    (CLK),
    .rst_ni   (RESET_N),
    .row_i    (s1_row_q),
    .col_i    (s1_col_q),
    .area_i   (s1_area_q),
    .blocks_i (blocks_s2_q),
    .hit_o    (s2_hit),
    .row_o    (s2_row)
  );

  logic [7:0] rgb;

  always_comb begin
    rgb = s2_lost_q ? COLOUR_LOST : COLOUR_BG;
    if (!s2_valid_q)    rgb = COLOUR_BG;
    else if (s2_ball_q) rgb = COLOUR_BALL;
    else if (s2_pad_q)  rgb = COLOUR_PADDLE;
    else if (s2_hit) begin
`ifdef FRAME_RENDERER_OUTLINE_EN
      rgb = s2_edge_q ? COLOUR_BG : ROW_COLOUR[s2_row];
`else
      rgb = ROW_COLOUR[s2_row];
`endif
    end
    else if (s2_wall_q) rgb = COLOUR_WALL;
  end

  assign RGB          = rgb;
  assign RGB_VALID    = s2_valid_q;
  assign START_UPDATE = start_q;

endmodule
